// File: rtl/mem_responder_if.sv
// Core-to-memory word bus: request fields from the core, completion back.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  modport master (output req, we, be, addr, wdata, input rdata, ready, err);
  modport slave  (input req, we, be, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_responder.sv
// Word-wide memory responder with configurable wait states, byte-enable
// writes and rejection of misaligned / out-of-range accesses.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  // Request being resolved this cycle: live inputs when going straight
  // from IDLE to RESP, otherwise the copy latched at acceptance.
  req_t            cur;
  logic            to_resp;
  logic            bad;
  logic            mem_we;
  logic [AW-1:0]   idx;

  logic [31:0]     mem [DEPTH_WORDS];

  // Next-state, counter, and response computation on the edge into RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    to_resp = 1'b0;
    cur     = req_q;
    case (state_q)
      IDLE: if (bus.req) begin
        cur.we    = bus.we;
        cur.be    = bus.be;
        cur.addr  = bus.addr;
        cur.wdata = bus.wdata;
        req_d     = cur;
        cnt_d     = CW'(WAIT_STATES);
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
        end else begin
          state_d = RESP;
          to_resp = 1'b1;
        end
      end
      WAIT: if (cnt_q == CW'(1)) begin
        state_d = RESP;
        cnt_d   = '0;
        to_resp = 1'b1;
      end else begin
        cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    idx    = cur.addr[AW+1:2];
    bad    = (cur.addr[1:0] != 2'b00) || (cur.addr[31:AW+2] != '0);
    mem_we = to_resp && cur.we && !bad;

    if (to_resp) begin
      ready_d = 1'b1;
      err_d   = bad;
      if (bad)          rdata_d = '0;
      else if (!cur.we) rdata_d = mem[idx];
    end
  end

  // State and outputs reset asynchronously; the array is only written
  // outside reset, so a transaction cut off by reset never commits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (cur.be[i]) mem[idx][8*i +: 8] <= cur.wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: DUT A with two wait states, DUT B with none.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_responder_if ifa ();
  mem_responder_if ifb ();

  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input int sel, input logic r, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      ifa.req = r; ifa.we = w; ifa.be = b; ifa.addr = a; ifa.wdata = d;
    end else begin
      ifb.req = r; ifb.we = w; ifb.be = b; ifb.addr = a; ifb.wdata = d;
    end
  endtask

  // One request; k = negedges after the accept edge until ready (-1 on timeout).
  task automatic txn(input int sel, input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er, output int k);
    logic rdy;
    @(posedge clk); #1;
    drive(sel, 1'b1, w, b, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    k = -1; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? ifa.ready : ifb.ready;
      if (rdy) begin
        k  = i;
        rd = (sel == 0) ? ifa.rdata : ifb.rdata;
        er = (sel == 0) ? ifa.err : ifb.err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++; if (ifa.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ifa.ready); end
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", ifa.err); end
    checks++; if (ifa.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", ifa.rdata); end
    checks++; if (ifb.ready !== 1'b0) begin errors++; $display("FAIL rst_ready_b got %b want 0", ifb.ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int k;
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, k);
    checks++; if (k !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", k); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    @(negedge clk);
    checks++; if (ifa.ready !== 1'b0 || ifa.err !== 1'b0) begin errors++; $display("FAIL ready_pulse got %b%b want 00", ifa.ready, ifa.err); end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    checks++; if (k !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", k); end
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL rd_data got %h/%b want deadbeef/0", rd, er); end
  endtask

  task automatic test_byte_enables;
    logic [31:0] rd; logic er; int k;
    txn(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, rd, er, k);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_holds_rdata got %h want deadbeef", rd); end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    checks++; if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0001 got %h want deadbeaa", rd); end
    txn(0, 1'b1, 4'b1000, 32'h10, 32'h55000000, rd, er, k);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    checks++; if (rd !== 32'h55ADBEAA) begin errors++; $display("FAIL be1000 got %h want 55adbeaa", rd); end
    txn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, k);
    checks++; if (er !== 1'b0 || k !== 3) begin errors++; $display("FAIL be0000 got err %b k %0d want 0 3", er, k); end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    checks++; if (rd !== 32'h55ADBEAA) begin errors++; $display("FAIL be0000_data got %h want 55adbeaa", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int k;
    txn(0, 1'b0, 4'h0, 32'h12, 32'h0, rd, er, k);
    checks++; if (k !== 3 || er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_rd got k%0d %b %h want k3 1 0", k, er, rd); end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    txn(0, 1'b1, 4'hF, 32'h12, 32'hFFFFFFFF, rd, er, k);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misalign_wr got %b %h want 1 0", er, rd); end
    @(negedge clk);
    checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL err_only_with_ready got %b want 0", ifa.err); end
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, k);
    checks++; if (rd !== 32'h55ADBEAA || er !== 1'b0) begin errors++; $display("FAIL misalign_wr_nochange got %h want 55adbeaa", rd); end
    txn(0, 1'b0, 4'h0, 32'h100, 32'h0, rd, er, k);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_rd got %b %h want 1 0", er, rd); end
    txn(0, 1'b1, 4'hF, 32'hFC, 32'h0BADF00D, rd, er, k);
    txn(0, 1'b0, 4'h0, 32'hFC, 32'h0, rd, er, k);
    checks++; if (er !== 1'b0 || rd !== 32'h0BADF00D) begin errors++; $display("FAIL last_word got %b %h want 0 0badf00d", er, rd); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd; logic er; int k; int seen;
    txn(0, 1'b1, 4'hF, 32'h20, 32'h22222222, rd, er, k);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, k);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL pre_reset_rd got %h want 22222222", rd); end
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'h11111111);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #2 reset = 1'b0;
    #1;
    checks++; if (ifa.ready !== 1'b0 || ifa.err !== 1'b0 || ifa.rdata !== 32'h0) begin
      errors++; $display("FAIL mid_rst_outputs got %b %b %h want 0 0 0", ifa.ready, ifa.err, ifa.rdata); end
    seen = 0;
    repeat (3) begin @(negedge clk); if (ifa.ready) seen++; end
    reset = 1'b1;
    repeat (4) begin @(negedge clk); if (ifa.ready) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_ready got %0d want 0", seen); end
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, k);
    checks++; if (rd !== 32'h22222222 || er !== 1'b0) begin errors++; $display("FAIL mid_rst_mem got %h want 22222222", rd); end
  endtask

  // req held high; next request presented as soon as ready is seen.
  task automatic test_back_to_back(input int sel, input int period);
    logic [31:0] rd; logic er; logic rdy;
    logic        w_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] a_t [5] = '{32'h30, 32'h30, 32'h34, 32'h34, 32'h30};
    logic [31:0] d_t [5] = '{32'h12345678, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0};
    logic [31:0] e_t [5] = '{32'h0, 32'h12345678, 32'h0, 32'hCAFEF00D, 32'h12345678};
    int n = 0; int last = -1; int cyc = 0;
    @(posedge clk); #1;
    drive(sel, 1'b1, w_t[0], 4'hF, a_t[0], d_t[0]);
    while (n < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      rdy = (sel == 0) ? ifa.ready : ifb.ready;
      if (rdy) begin
        rd = (sel == 0) ? ifa.rdata : ifb.rdata;
        er = (sel == 0) ? ifa.err : ifb.err;
        if (last >= 0) begin
          checks++; if (cyc - last !== period) begin errors++; $display("FAIL b2b_period[%0d] dut%0d got %0d want %0d", n, sel, cyc - last, period); end
        end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL b2b_err[%0d] dut%0d got %b want 0", n, sel, er); end
        if (!w_t[n]) begin
          checks++; if (rd !== e_t[n]) begin errors++; $display("FAIL b2b_data[%0d] dut%0d got %h want %h", n, sel, rd, e_t[n]); end
        end
        last = cyc;
        n++;
        if (n < 5) drive(sel, 1'b1, w_t[n], 4'hF, a_t[n], d_t[n]);
        else       drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_count dut%0d got %0d want 5", sel, n); end
    drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_wait;
    logic [31:0] rd; logic er; int k;
    txn(1, 1'b1, 4'hF, 32'h40, 32'hA5A5_5A5A, rd, er, k);
    checks++; if (k !== 1 || er !== 1'b0) begin errors++; $display("FAIL zw_wr got k%0d %b want k1 0", k, er); end
    txn(1, 1'b0, 4'h0, 32'h40, 32'h0, rd, er, k);
    checks++; if (k !== 1 || rd !== 32'hA5A55A5A) begin errors++; $display("FAIL zw_rd got k%0d %h want k1 a5a55a5a", k, rd); end
    txn(1, 1'b0, 4'h0, 32'h41, 32'h0, rd, er, k);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL zw_misalign got %b %h want 1 0", er, rd); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_write_read();
    test_byte_enables();
    test_errors();
    test_reset_mid_write();
    test_back_to_back(0, 4);
    test_zero_wait();
    test_back_to_back(1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle ARM core's unified instruction/data bus. It accepts one word request at a time from the core's memory port and models configurable wait states. It commits writes with byte enables, returns read data, and flags misaligned or out-of-range accesses. It sits between the core datapath's address/write-data outputs and its read-data input, and supplies the `ready` handshake the core's state machine waits on.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words stored; power of two, ≥ 4.
- `WAIT_STATES`, 2: idle cycles inserted between acceptance and response; 0–15.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req`  in  1  request valid from the core.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `be`  in  4  byte enables for writes; bit i selects byte i (`wdata[8i+7:8i]`); ignored on reads.
- `addr`  in  32  byte address; must be word-aligned.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid while `ready`=1, held until the next completed read or error.
- `ready`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `ready`; 1 = access rejected.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `req`=1 is accepted. `we`, `be`, `addr`, `wdata` are latched into internal registers.
  - The wait counter loads `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES`>0, else RESP.
- **WAIT**
  - The counter decrements each cycle. When it reaches 1, next state is RESP.
  - Input changes are ignored; only latched values are used.
- **Transition into RESP** (same edge)
  - The error check runs on latched `addr`. Error if `addr[1:0]`≠0 or `addr[31:2]` ≥ `DEPTH_WORDS`.
  - Error: no memory update; `rdata`←0; `err`←1.
  - Write, no error: only bytes with `be[i]`=1 are updated; `rdata` is unchanged; `err`←0.
  - Read, no error: `rdata`←mem[`addr[31:2]`]; `err`←0.
  - `be`=0000 on a write is legal and completes with no change.
- **RESP**
  - `ready`=1 for exactly this cycle. Next state is IDLE.
  - `req` in RESP is not sampled.
- **Initiator rule:** the core drops `req` in the cycle after it sees `ready`. A `req` still high in the following IDLE cycle is accepted as a new transaction.
- **Memory array**
  - The memory array is not reset.
  - Contents survive `reset`. They are undefined until written.
- **Counter width:** max(1, clog2(`WAIT_STATES`+1)).

## Timing
- **Reset values:** state=IDLE, `ready`=0, `err`=0, `rdata`=0, counter=0.
- **Reset while asserted**
  - All outputs are forced immediately (asynchronous).
  - A transaction pending in WAIT is dropped; its write is never committed.
  - Release is synchronous to the next rising edge.
- **Latency:** request accepted at edge N. `ready` is high during cycle N+1+`WAIT_STATES`.
- **Throughput:** one transaction per `WAIT_STATES`+2 cycles with `req` held high continuously.
- `ready` and `err` are registered outputs. No combinational path from inputs to outputs.
- `err`=1 only while `ready`=1; 0 otherwise.

## Test plan
- **Reset:** `reset`=0 mid-simulation, including during WAIT → `ready`=0, `err`=0, `rdata`=0 immediately; state returns to IDLE.
- **Write then read** (`WAIT_STATES`=2): write 0xDEADBEEF to 0x10, `be`=1111, accepted at edge N → `ready` in cycle N+3, `err`=0. Then read 0x10 → `rdata`=0xDEADBEEF with `ready`.
- **Byte enables:** write 0x000000AA to 0x10 with `be`=0001 → read 0x10 returns 0xDEADBEAA. Then write 0x55000000 with `be`=1000 → read returns 0x55ADBEAA.
- **Errors, misaligned:** read 0x12 → `ready`=1, `err`=1, `rdata`=0. Write 0x12 leaves word 0x10 unchanged.
- **Errors, out of range:** read 0x100 (`DEPTH_WORDS`=64) → `err`=1.
- **Reset mid-write:** mem[0x20]=0x22222222. Start write 0x11111111 to 0x20, then pulse `reset` low during WAIT → no `ready`. Subsequent read of 0x20 returns 0x22222222.
- **Back-to-back:** `req` held high across alternating writes/reads → `ready` pulses every 4 cycles (`WAIT_STATES`=2). `WAIT_STATES`=0 build → `ready` every 2 cycles, data correct each time.
